// File: rtl/mux_arbiter.sv
// Two-requester arbiter for a shared 2:1 mux: drives se/en and a registered copy of the selected data.
// Round-robin with bounded hold by default; define MUX_ARB_PRIO_EN for fixed A-over-B priority.
module mux_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             se,
  output logic             en,
  output logic [WIDTH-1:0] c,
  output logic             c_valid
);

  // state   | meaning
  // S_IDLE  | no owner, mux disabled
  // S_GNT_A | requester A owns the mux (se = 0)
  // S_GNT_B | requester B owns the mux (se = 1)
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2
  } state_t;

  localparam int            CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_TOP = CW'(MAX_HOLD - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_hold_cnt;
  logic          r_last_b;
  logic          w_hold_max;

  assign w_hold_max = (r_hold_cnt == HOLD_TOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_last_b   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_hold_cnt <= '0;
      else if (r_state != S_IDLE && !w_hold_max)
        r_hold_cnt <= r_hold_cnt + 1'b1;
      if (w_next == S_GNT_A && r_state != S_GNT_A)
        r_last_b <= 1'b0;
      else if (w_next == S_GNT_B && r_state != S_GNT_B)
        r_last_b <= 1'b1;
    end
  end

`ifdef MUX_ARB_PRIO_EN
  // Fixed priority: A always wins and preempts B.
  always_comb begin
    w_next = S_IDLE;
    if (req_a)
      w_next = S_GNT_A;
    else if (req_b)
      w_next = S_GNT_B;
  end
`else
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_a && req_b)
          w_next = r_last_b ? S_GNT_A : S_GNT_B;
        else if (req_a)
          w_next = S_GNT_A;
        else if (req_b)
          w_next = S_GNT_B;
      end
      S_GNT_A: begin
        if (!req_a)
          w_next = req_b ? S_GNT_B : S_IDLE;
        else if (req_b && w_hold_max)
          w_next = S_GNT_B;
      end
      S_GNT_B: begin
        if (!req_b)
          w_next = req_a ? S_GNT_A : S_IDLE;
        else if (req_a && w_hold_max)
          w_next = S_GNT_A;
      end
      default: w_next = S_IDLE;
    endcase
  end
`endif

  always_comb begin
    gnt_a = (r_state == S_GNT_A);
    gnt_b = (r_state == S_GNT_B);
    en    = gnt_a | gnt_b;
    se    = gnt_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c       <= '0;
      c_valid <= 1'b0;
    end else if (gnt_a) begin
      c       <= a;
      c_valid <= 1'b1;
    end else if (gnt_b) begin
      c       <= b;
      c_valid <= 1'b1;
    end else begin
      c_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios plus random traffic against an owner/run-length model.
// Honours MUX_ARB_PRIO_EN the same way the design does.
module tb_mux_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_a, req_b;
  logic [W-1:0] a, b;
  logic         gnt_a, gnt_b, se, en, c_valid;
  logic [W-1:0] c;

  int n_checks = 0;
  int n_err    = 0;

  // model: owner 0 = none, 1 = A, 2 = B; run = cycles owned so far
  int           m_own, m_run, m_last;
  logic [W-1:0] m_c;
  logic         m_v;

  mux_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .se(se), .en(en), .c(c), .c_valid(c_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = 0;
    m_run  = 0;
    m_last = 2;
    m_c    = '0;
    m_v    = 1'b0;
  endtask

  task automatic model_step(input logic ra, input logic rb, input logic [W-1:0] av,
                            input logic [W-1:0] bv);
    int nxt, oth;
    logic mine, other;
    if (m_own == 1) begin m_c = av; m_v = 1'b1; end
    else if (m_own == 2) begin m_c = bv; m_v = 1'b1; end
    else m_v = 1'b0;
`ifdef MUX_ARB_PRIO_EN
    nxt = ra ? 1 : (rb ? 2 : 0);
`else
    if (m_own == 0) begin
      if (ra && rb) nxt = (m_last == 1) ? 2 : 1;
      else          nxt = ra ? 1 : (rb ? 2 : 0);
    end else begin
      mine  = (m_own == 1) ? ra : rb;
      other = (m_own == 1) ? rb : ra;
      oth   = 3 - m_own;
      if (!mine)                     nxt = other ? oth : 0;
      else if (other && m_run >= MH) nxt = oth;
      else                           nxt = m_own;
    end
`endif
    if (nxt != m_own) begin
      m_run = (nxt != 0) ? 1 : 0;
      if (nxt != 0) m_last = nxt;
    end else if (nxt != 0) begin
      m_run++;
    end
    m_own = nxt;
  endtask

  task automatic check_all();
    chk("gnt_a",   gnt_a,   m_own == 1);
    chk("gnt_b",   gnt_b,   m_own == 2);
    chk("se",      se,      m_own == 2);
    chk("en",      en,      m_own != 0);
    chk("c_valid", c_valid, m_v);
    chk("c",       c,       m_c);
  endtask

  task automatic step(input logic ra, input logic rb, input logic [W-1:0] av,
                      input logic [W-1:0] bv);
    req_a = ra; req_b = rb; a = av; b = bv;
    model_step(ra, rb, av, bv);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Called at posedge+1: reset is asserted and released between edges.
  task automatic reset_mid();
    #3 rst = 1'b1;
    #1;
    chk("rst_gnt_a",   gnt_a,   0);
    chk("rst_gnt_b",   gnt_b,   0);
    chk("rst_en",      en,      0);
    chk("rst_se",      se,      0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c",       c,       0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  initial begin
    bit seen_a;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // single requester
    for (int i = 0; i < 3; i++) step(1, 0, 4'b1010, 4'b0000);
    chk("single_c", c, 4'b1010);
    step(0, 0, 4'b1010, 4'b0000);
    step(0, 0, 4'b0011, 4'b0000);
    chk("drop_c_hold", c, 4'b1010);
    chk("drop_valid",  c_valid, 0);

    // reset mid-grant, then A wins the first tie
    step(1, 0, 4'b0110, 4'b0000);
    reset_mid();
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 4'b1111, 4'b0000);
`ifdef MUX_ARB_PRIO_EN
      chk("prio_tie_b", gnt_b, 0);
`else
      chk("tie_rot", gnt_a, ((i / MH) % 2) == 0);
`endif
    end

    // direct handover without idle bubble
    step(1, 1, 4'b1111, 4'b0000);
    step(0, 1, 4'b1111, 4'b0101);
    chk("handover_en", en, 1);
    step(0, 1, 4'b1111, 4'b0101);
    chk("handover_c", c, 4'b0101);

    // idle
    step(0, 0, 4'b0000, 4'b0000);
    step(0, 0, 4'b0000, 4'b0000);
    chk("idle_en", en, 0);
    chk("idle_valid", c_valid, 0);

    // no starvation: B holds alone, then A must get in within MAX_HOLD cycles
    for (int i = 0; i < 6; i++) step(0, 1, 4'b0001, 4'b0010);
    chk("b_hold", gnt_b, 1);
    seen_a = 1'b0;
    for (int i = 0; i < MH; i++) begin
      step(1, 1, 4'b0001, 4'b0010);
      if (gnt_a) seen_a = 1'b1;
    end
    chk("no_starve", seen_a, 1);

    // random traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, W'($urandom), W'($urandom));
      if ($urandom_range(0, 49) == 0) reset_mid();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
